// File: rtl/conv_pkg.sv
// Width and saturation helpers shared by the streaming KxK convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    POST_PASS,
    POST_CLAMP_HI,
    POST_CLAMP_LO
  } post_e;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Index/pointer width that stays at least one bit for degenerate sizes.
  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int k);
    return data_w + coef_w + 1 + clog2(k * k);
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/conv2d_stream_line_buffer.sv
// Circular delay line of DEPTH enabled samples; the read port is a register
// prefetched from the slot that will be overwritten next.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PTR_W = addr_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [DATA_W-1:0] dout_reg;

  assign ptr_next = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (en) mem[ptr_reg] <= din;
  end

  // A depth-1 line would read the slot being written, so bypass din then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg  <= '0;
      dout_reg <= '0;
    end else if (en) begin
      ptr_reg  <= ptr_next;
      dout_reg <= (ptr_next == ptr_reg) ? din : mem[ptr_next];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution: window/line buffers (S0), products (S1),
// adder tree (S2) and ReLU/saturation post-processing (S3).
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int OUT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          pxl_in,
  input  logic                       coef_we,
  input  logic [addr_w(K*K)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       relu_en,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           pxl_out,
  output logic                       out_last,
  output logic                       sat_flag
);

  localparam int KK     = K * K;
  localparam int CA_W   = addr_w(KK);
  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, K);
  localparam int COL_W  = addr_w(IMG_W);
  localparam int ROW_W  = addr_w(IMG_H);
  localparam longint SAT_MAX = sat_max(OUT_W);
  localparam longint SAT_MIN = sat_min(OUT_W);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             col_last;
  logic             row_last;
  logic             win_ok;

  assign col_last = (col_reg == COL_W'(IMG_W - 1));
  assign row_last = (row_reg == ROW_W'(IMG_H - 1));
  // Windows that would straddle a row wrap or reach above row 0 are dropped here.
  assign win_ok   = in_valid && (row_reg >= ROW_W'(K - 1)) && (col_reg >= COL_W'(K - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // ---------------- S0: window and line buffers ----------------
  logic [DATA_W-1:0] win_reg [K][K];
  logic [DATA_W-1:0] col_in  [K];
  logic [DATA_W-1:0] win_flat [KK];

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      if (gi == K - 1) begin : g_live
        assign col_in[gi] = pxl_in;
      end else begin : g_lb
        // Fed from the right-column tap of the row below, so total delay is one image row.
        line_buffer #(
          .DATA_W (DATA_W),
          .DEPTH  (IMG_W - 1)
        ) u_line_buffer (
          .clk   (clk),
          .reset (reset),
          .en    (in_valid),
          .din   (win_reg[gi+1][K-1]),
          .dout  (col_in[gi])
        );
      end
    end

    for (gi = 0; gi < KK; gi++) begin : g_flat
      assign win_flat[gi] = win_reg[gi / K][gi % K];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) win_reg[r][c] <= '0;
      end
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_reg[r][c] <= win_reg[r][c+1];
        win_reg[r][K-1] <= col_in[r];
      end
    end
  end

  // ---------------- coefficient bank ----------------
  logic signed [COEF_W-1:0] coef_reg [KK];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KK; i++) coef_reg[i] <= '0;
    end else begin
      for (int i = 0; i < KK; i++) begin
        if (coef_we && (coef_addr == CA_W'(i))) coef_reg[i] <= coef_data;
      end
    end
  end

  // ---------------- pipeline qualifiers ----------------
  logic s0_valid_reg, s1_valid_reg, s2_valid_reg;
  logic s0_last_reg,  s1_last_reg,  s2_last_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s0_last_reg  <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_last_reg  <= 1'b0;
    end else begin
      s0_valid_reg <= win_ok;
      s0_last_reg  <= win_ok && col_last && row_last;
      s1_valid_reg <= s0_valid_reg;
      s1_last_reg  <= s0_last_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
    end
  end

  // ---------------- S1: products ----------------
  logic signed [PROD_W-1:0] prod_reg [KK];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KK; i++) prod_reg[i] <= '0;
    end else begin
      for (int i = 0; i < KK; i++) begin
        prod_reg[i] <= PROD_W'($signed({1'b0, win_flat[i]})) * PROD_W'(coef_reg[i]);
      end
    end
  end

  // ---------------- S2: accumulate ----------------
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    relu_reg;

  always_comb begin
    sum = '0;
    for (int i = 0; i < KK; i++) sum = sum + ACC_W'(prod_reg[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg  <= '0;
      relu_reg <= 1'b0;
    end else begin
      acc_reg  <= sum;
      relu_reg <= relu_en;
    end
  end

  // ---------------- S3: ReLU / saturate ----------------
  logic signed [63:0] acc_ext;
  logic signed [63:0] post_val;
  post_e              post_sel;
  logic [OUT_W-1:0]   post_out;

  always_comb begin
    acc_ext  = 64'(acc_reg);
    post_val = (relu_reg && (acc_ext < 0)) ? 64'sd0 : acc_ext;
    post_sel = POST_PASS;
    if (post_val > SAT_MAX)      post_sel = POST_CLAMP_HI;
    else if (post_val < SAT_MIN) post_sel = POST_CLAMP_LO;
    case (post_sel)
      POST_CLAMP_HI: post_out = OUT_W'(SAT_MAX);
      POST_CLAMP_LO: post_out = OUT_W'(SAT_MIN);
      default:       post_out = post_val[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      pxl_out   <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= s2_valid_reg;
      out_last  <= s2_valid_reg && s2_last_reg;
      sat_flag  <= s2_valid_reg && (post_sel != POST_PASS);
      if (s2_valid_reg) pxl_out <= post_out;
    end
  end

endmodule
